counter_mod: RTL and testbench
==============================

# counter_mod

Parametrised modulo up/down counter, the next generation of the team's 3-bit enable/clear counter. It adds configurable width and modulus, a direction input, parallel load, a prescaler and registered wrap flags. It acts as a stimulus or timebase source in benches and as a sequencing counter in datapaths. One clock domain; all outputs registered.

## Interface
- `WIDTH`, default 8: counter width in bits, range 2..32.
- `MAX_VAL`, default 2^WIDTH-1: terminal value. The count runs 0..MAX_VAL and requires 1 ≤ MAX_VAL ≤ 2^WIDTH-1.
- `PRESCALE`, default 1: number of enabled clocks per count step, range 1..65535.
- `clk` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `EN` in 1: enable. Advances the prescaler and count.
- `CLR` in 1: synchronous clear.
- `LD` in 1: synchronous parallel load.
- `LD_VAL` in WIDTH: load value.
- `UP` in 1: direction. 1 = increment, 0 = decrement.
- `counter` out WIDTH: current count.
- `OV` out 1: one-cycle pulse on an up-wrap MAX_VAL→0.
- `UF` out 1: one-cycle pulse on a down-wrap 0→MAX_VAL.
- `OV_STICKY` out 1: latched OR of OV and UF events.
- `TC` out 1: terminal count. Equals (counter==MAX_VAL) when UP=1, and (counter==0) when UP=0. This is the only combinational output.

## Operation
- Internal prescaler `presc` is ceil(log2(PRESCALE)) bits wide, minimum 1 bit.
- **Reset low, asynchronous:** `counter`=0, `presc`=0, `OV`=0, `UF`=0, `OV_STICKY`=0. This holds regardless of clk. Reset mid-step discards that step.
- **Per-edge priority:** Reset > CLR > LD > EN > idle.
  - **CLR=1:** `counter`←0, `presc`←0, `OV_STICKY`←0, `OV`/`UF`←0.
  - **LD=1, CLR=0:** `counter`←min(LD_VAL, MAX_VAL), `presc`←0, `OV`/`UF`←0. `OV_STICKY` holds.
  - **EN=1, no CLR/LD, presc≠PRESCALE-1:** `presc`←presc+1. Count holds, `OV`/`UF`←0.
  - **EN=1, no CLR/LD, presc==PRESCALE-1 (a step):** `presc`←0.
    - UP=1: `counter`←(counter==MAX_VAL) ? 0 : counter+1. `OV`←1 on wrap, else 0.
    - UP=0: `counter`←(counter==0) ? MAX_VAL : counter-1. `UF`←1 on wrap, else 0.
    - On either wrap, `OV_STICKY`←1.
  - **EN=0, no CLR/LD:** `counter` and `presc` hold, `OV`/`UF`←0.
- **Arithmetic:** modulo MAX_VAL+1, never outside 0..MAX_VAL. No intermediate width overflow even when MAX_VAL=2^WIDTH-1.
- **Direction change:** `UP` is sampled only at step edges and may change at any time. No extra or skipped step results.
- **Simultaneous CLR and step at a wrap:** CLR wins. No `OV`/`UF` pulse and `OV_STICKY` ends at 0.
- **LD_VAL > MAX_VAL:** the load clamps silently to MAX_VAL.

## Timing
- `counter` updates on the same rising edge that samples the controls, so step latency is 1 clock.
- `OV`/`UF` are high for exactly the one cycle in which `counter` shows the wrapped value.
- With EN held high, the step period is PRESCALE clocks. The first step after reset, CLR or LD comes PRESCALE edges later.
- `TC` follows `counter` and `UP` combinationally, with no register delay.
- Reset release is sampled at the next rising edge. The first count action happens on the first edge with Reset=1.

## Test plan
- **Reset.** Params WIDTH=4, MAX_VAL=9, PRESCALE=1. Hold Reset=0 for 3 clocks, with EN=1 and LD=1 active → `counter`=0, `OV`=`UF`=`OV_STICKY`=0 throughout.
- **Up wrap.** Same params, EN=1, UP=1, for 12 edges after reset → `counter` reads 1..9,0,1,2. `OV`=1 only in the cycle counter=0. `OV_STICKY`=1 from then on. `TC`=1 when counter=9.
- **Down wrap.** Same params, reset, then EN=1, UP=0 → the first edge gives counter=9 with `UF`=1. The next edges give 8,7…; `TC`=1 at 0.
- **Prescale.** Params WIDTH=8, PRESCALE=3, EN=1, UP=1. Deassert EN for 2 clocks mid-run → count advances every 3rd enabled edge (0,0,0,1,1,1,2…). It holds while EN=0, with no lost or extra step.
- **Load and clear.** Params WIDTH=4, MAX_VAL=9.
  - LD=1 with LD_VAL=13 → counter=9, `presc`=0.
  - Next edge: LD with CLR=1, LD_VAL=5 → counter=0 and `OV_STICKY` cleared (CLR beats LD).
- **Full-range wrap.** Params WIDTH=3, MAX_VAL=7, UP=1, EN=1 for 8 edges from 0 → 1..7,0. `OV` pulses on 7→0. Assert CLR on that same wrap edge in a second run → counter=0, `OV`=0, `OV_STICKY`=0.

Source files
------------

// File: rtl/counter_mod.sv
// ---------------------------------------------------------------------------
// counter_mod
//   Parametrised modulo up/down counter with prescaler, parallel load,
//   synchronous clear and registered wrap flags. The count always stays
//   within 0..MAX_VAL and wraps modulo MAX_VAL+1.
//
// Parameters
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   terminal value, 1..2^WIDTH-1 (default 2^WIDTH-1)
//   PRESCALE  enabled clocks per count step (1..65535)
//
// Ports
//   clk        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   EN         in   enable, advances prescaler and count
//   CLR        in   synchronous clear (highest synchronous priority)
//   LD         in   synchronous parallel load of min(LD_VAL, MAX_VAL)
//   LD_VAL     in   load value
//   UP         in   direction: 1 = increment, 0 = decrement
//   counter    out  current count (registered)
//   OV         out  one-cycle pulse on an up-wrap MAX_VAL -> 0
//   UF         out  one-cycle pulse on a down-wrap 0 -> MAX_VAL
//   OV_STICKY  out  latched OR of wrap events, cleared by reset/CLR
//   TC         out  terminal count for the current direction (combinational)
// ---------------------------------------------------------------------------
module counter_mod #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic             UP,
    output logic [WIDTH-1:0] counter,
    output logic             OV,
    output logic             UF,
    output logic             OV_STICKY,
    output logic             TC
);

    // Prescaler is ceil(log2(PRESCALE)) bits, never narrower than one bit.
    localparam int              PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PTERM = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   PONE  = PW'(1);
    localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_presc;
    logic             r_ov;
    logic             r_uf;
    logic             r_sticky;

    logic             w_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_ld_clamped;

    assign w_step       = (r_presc == PTERM);
    assign w_at_max     = (r_count == MAXV);
    assign w_at_zero    = (r_count == '0);
    // Loads above the terminal value saturate at MAX_VAL.
    assign w_ld_clamped = (LD_VAL > MAXV) ? MAXV : LD_VAL;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_count  <= '0;
            r_presc  <= '0;
            r_ov     <= 1'b0;
            r_uf     <= 1'b0;
            r_sticky <= 1'b0;
        end else if (CLR) begin
            r_count  <= '0;
            r_presc  <= '0;
            r_ov     <= 1'b0;
            r_uf     <= 1'b0;
            r_sticky <= 1'b0;
        end else if (LD) begin
            r_count  <= w_ld_clamped;
            r_presc  <= '0;
            r_ov     <= 1'b0;
            r_uf     <= 1'b0;
        end else if (EN) begin
            r_ov <= 1'b0;
            r_uf <= 1'b0;
            if (w_step) begin
                r_presc <= '0;
                // Wrap is detected by comparison before the +/-1, so the
                // adder never needs a carry bit even when MAX_VAL is all ones.
                if (UP) begin
                    if (w_at_max) begin
                        r_count  <= '0;
                        r_ov     <= 1'b1;
                        r_sticky <= 1'b1;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end else begin
                    if (w_at_zero) begin
                        r_count  <= MAXV;
                        r_uf     <= 1'b1;
                        r_sticky <= 1'b1;
                    end else begin
                        r_count <= r_count - ONE;
                    end
                end
            end else begin
                r_presc <= r_presc + PONE;
            end
        end else begin
            r_ov <= 1'b0;
            r_uf <= 1'b0;
        end
    end

    assign counter   = r_count;
    assign OV        = r_ov;
    assign UF        = r_uf;
    assign OV_STICKY = r_sticky;
    assign TC        = UP ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Three instances: (WIDTH,MAX,PRESCALE) = (4,9,1), (8,255,3), (3,7,1)
    localparam int MX[3] = '{9, 255, 7};
    localparam int PS[3] = '{1, 3, 1};
    localparam int WD[3] = '{4, 8, 3};

    logic       en[3], clr[3], ld[3], up[3];
    logic [7:0] ldv[3];
    logic [3:0] c0;
    logic [7:0] c1;
    logic [2:0] c2;
    logic       ov[3], uf[3], st[3], tc[3];

    counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u0 (
        .clk(clk), .Reset(rstn), .EN(en[0]), .CLR(clr[0]), .LD(ld[0]),
        .LD_VAL(ldv[0][3:0]), .UP(up[0]), .counter(c0), .OV(ov[0]),
        .UF(uf[0]), .OV_STICKY(st[0]), .TC(tc[0]));
    counter_mod #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(3)) u1 (
        .clk(clk), .Reset(rstn), .EN(en[1]), .CLR(clr[1]), .LD(ld[1]),
        .LD_VAL(ldv[1]), .UP(up[1]), .counter(c1), .OV(ov[1]),
        .UF(uf[1]), .OV_STICKY(st[1]), .TC(tc[1]));
    counter_mod #(.WIDTH(3), .MAX_VAL(7), .PRESCALE(1)) u2 (
        .clk(clk), .Reset(rstn), .EN(en[2]), .CLR(clr[2]), .LD(ld[2]),
        .LD_VAL(ldv[2][2:0]), .UP(up[2]), .counter(c2), .OV(ov[2]),
        .UF(uf[2]), .OV_STICKY(st[2]), .TC(tc[2]));

    int checks = 0;
    int errors = 0;

    // Behavioural model state: count, enabled-edge tally since last step, flags
    int mc[3], mp[3], mov[3], muf[3], mst[3];

    function automatic int cval(int i);
        case (i)
            0:       return int'(c0);
            1:       return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mp[i] = 0; mov[i] = 0; muf[i] = 0; mst[i] = 0;
        end
    endtask

    task automatic model_update();
        int v;
        for (int i = 0; i < 3; i++) begin
            mov[i] = 0;
            muf[i] = 0;
            if (clr[i]) begin
                mc[i] = 0; mp[i] = 0; mst[i] = 0;
            end else if (ld[i]) begin
                v     = int'(ldv[i]) % (1 << WD[i]);
                mc[i] = (v > MX[i]) ? MX[i] : v;
                mp[i] = 0;
            end else if (en[i]) begin
                mp[i]++;
                if (mp[i] == PS[i]) begin
                    mp[i] = 0;
                    if (up[i]) begin
                        mc[i]  = (mc[i] + 1) % (MX[i] + 1);
                        mov[i] = (mc[i] == 0) ? 1 : 0;
                    end else begin
                        mc[i]  = (mc[i] + MX[i]) % (MX[i] + 1);
                        muf[i] = (mc[i] == MX[i]) ? 1 : 0;
                    end
                    if (mov[i] == 1 || muf[i] == 1) mst[i] = 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge that the DUT just sampled.
    task automatic cyc();
        @(posedge clk);
        if (rstn) model_update();
        #1;
    endtask

    task automatic rst_pulse();
        rstn = 1'b0;
        model_reset();
        cyc();
        rstn = 1'b1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            en[i] = 0; clr[i] = 0; ld[i] = 0; up[i] = 1; ldv[i] = '0;
        end
    endtask

    // Compare process: every falling edge, all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cnt%0d", i), cval(i), mc[i]);
            chk($sformatf("ov%0d", i), int'(ov[i]), mov[i]);
            chk($sformatf("uf%0d", i), int'(uf[i]), muf[i]);
            chk($sformatf("sticky%0d", i), int'(st[i]), mst[i]);
            chk($sformatf("tc%0d", i), int'(tc[i]),
                (up[i] ? (mc[i] == MX[i]) : (mc[i] == 0)) ? 1 : 0);
        end
    end

    initial begin : drive
        int up_exp[12];
        int pre_en[11];
        int pre_exp[11];
        up_exp  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        pre_en  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        pre_exp = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

        idle_all();
        model_reset();
        rstn = 1'b0;

        // Reset held with EN and LD active
        en[0] = 1; ld[0] = 1; ldv[0] = 8'd5;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_cnt", int'(c0), 0);
            chk("rst_sticky", int'(st[0]), 0);
        end
        ld[0] = 0; up[0] = 1;
        rstn = 1'b1;

        // Up wrap on WIDTH=4 MAX=9
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("up_cnt", int'(c0), up_exp[k]);
            chk("up_ov", int'(ov[0]), (k == 9) ? 1 : 0);
            if (k == 8) chk("up_tc9", int'(tc[0]), 1);
        end
        chk("up_sticky", int'(st[0]), 1);

        // Down wrap
        en[0] = 0;
        rst_pulse();
        en[0] = 1; up[0] = 0;
        cyc();
        chk("dn_first", int'(c0), 9);
        chk("dn_uf", int'(uf[0]), 1);
        for (int k = 8; k >= 0; k--) begin
            cyc();
            chk("dn_cnt", int'(c0), k);
        end
        chk("dn_tc0", int'(tc[0]), 1);
        en[0] = 0;

        // Prescale = 3 with a mid-step EN pause
        rst_pulse();
        up[1] = 1;
        for (int k = 0; k < 11; k++) begin
            en[1] = pre_en[k][0];
            cyc();
            chk("presc_cnt", int'(c1), pre_exp[k]);
        end
        en[1] = 0;

        // Load clamp and CLR beating LD
        en[0] = 1; up[0] = 0;
        cyc();
        en[0] = 0;
        chk("ld_pre_sticky", int'(st[0]), 1);
        ld[0] = 1; ldv[0] = 8'd13;
        cyc();
        chk("ld_clamp", int'(c0), 9);
        chk("ld_sticky_hold", int'(st[0]), 1);
        clr[0] = 1; ldv[0] = 8'd5;
        cyc();
        chk("clr_cnt", int'(c0), 0);
        chk("clr_sticky", int'(st[0]), 0);
        ld[0] = 0; clr[0] = 0;

        // Full-range wrap, then CLR on the wrap edge
        rst_pulse();
        en[2] = 1; up[2] = 1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("full_cnt", int'(c2), k % 8);
        end
        chk("full_ov", int'(ov[2]), 1);
        rst_pulse();
        for (int k = 0; k < 7; k++) cyc();
        chk("full_at7", int'(c2), 7);
        clr[2] = 1;
        cyc();
        chk("clrwrap_cnt", int'(c2), 0);
        chk("clrwrap_ov", int'(ov[2]), 0);
        chk("clrwrap_sticky", int'(st[2]), 0);
        idle_all();

        // Randomised run on all instances, with occasional async resets
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++) begin
                clr[i] = ($urandom_range(0, 29) == 0);
                ld[i]  = ($urandom_range(0, 19) == 0);
                en[i]  = ($urandom_range(0, 3) != 0);
                up[i]  = ($urandom_range(0, 3) != 0) ? (n[8] ^ n[6]) : $urandom_range(0, 1);
                ldv[i] = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 149) == 0) begin
                rstn = 1'b0;
                model_reset();
            end else begin
                rstn = 1'b1;
            end
            cyc();
        end
        rstn = 1'b1;
        idle_all();
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
